// File: rtl/cache_axil_slave_pkg.sv
// Shared types and constants for the AXI4-Lite to native-bus bridge.
//  state_t : bridge FSM states
//  prio_t  : which kind of request wins when a read and a write are both pending
//  AXI_RESP_W / AXI_RESP_OKAY : AXI response field width and the OKAY code
package cache_axil_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_REQ = 3'd1,
        ST_WR_REQ = 3'd2,
        ST_RD_RSP = 3'd3,
        ST_WR_RSP = 3'd4
    } state_t;

    typedef enum logic {
        PRIO_READ  = 1'b0,
        PRIO_WRITE = 1'b1
    } prio_t;

    localparam int AXI_RESP_W = 2;
    localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/cache_axil_slave_hold_slot.sv
// Single-entry holding register for one AXI4-Lite channel (AR, AW or W).
//  clk, reset : clock, asynchronous active-high reset
//  in_valid   : channel valid from the master
//  in_data    : channel payload, captured on in_valid & in_ready
//  in_ready   : registered channel ready, high only while the slot is empty
//  free       : empties the slot (only asserted while the slot is full)
//  full       : slot holds an entry
//  data       : held payload
module axil_hold_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             free,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    logic             full_r;
    logic             ready_r;
    logic [WIDTH-1:0] data_r;

    // Capture/free the entry; ready mirrors "empty" one cycle late so it is a clean flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_r  <= 1'b0;
            ready_r <= 1'b0;
            data_r  <= '0;
        end else if (in_valid && ready_r) begin
            full_r  <= 1'b1;
            ready_r <= 1'b0;
            data_r  <= in_data;
        end else if (free) begin
            full_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            ready_r <= ~full_r;
        end
    end

    assign in_ready = ready_r;
    assign full     = full_r;
    assign data     = data_r;

endmodule

// File: rtl/cache_axil_slave.sv
// AXI4-Lite slave to native cache bus bridge with one outstanding native request.
//  clk, reset          : clock, asynchronous active-high reset
//  s_aw*/s_w*/s_b*     : AXI4-Lite write address, write data and write response
//  s_ar*/s_r*          : AXI4-Lite read address and read data
//  valid/addr/wdata/wstrb : native request, registered, held until ready (wstrb=0 means read)
//  ready/rdata         : one-cycle completion pulse and read data from the front end
// With CTRL_CACHE=1 the extra address MSB (cache-control select) is passed through untouched.
module cache_axil_slave
    import cache_axil_slave_pkg::*;
#(
    parameter int  FE_ADDR_W  = 32,
    parameter int  FE_DATA_W  = 32,
    parameter int  CTRL_CACHE = 0,
    localparam int FE_NBYTES  = FE_DATA_W / 8,
    localparam int AW         = CTRL_CACHE + FE_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AW-1:0]        s_awaddr,
    input  logic                 s_awvalid,
    output logic                 s_awready,
    input  logic [FE_DATA_W-1:0] s_wdata,
    input  logic [FE_NBYTES-1:0] s_wstrb,
    input  logic                 s_wvalid,
    output logic                 s_wready,
    output logic [1:0]           s_bresp,
    output logic                 s_bvalid,
    input  logic                 s_bready,
    input  logic [AW-1:0]        s_araddr,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    output logic [FE_DATA_W-1:0] s_rdata,
    output logic [1:0]           s_rresp,
    output logic                 s_rvalid,
    input  logic                 s_rready,
    output logic                 valid,
    output logic [AW-1:0]        addr,
    output logic [FE_DATA_W-1:0] wdata,
    output logic [FE_NBYTES-1:0] wstrb,
    input  logic                 ready,
    input  logic [FE_DATA_W-1:0] rdata
);

    localparam int WW = FE_DATA_W + FE_NBYTES;

    logic                 ar_full_s, aw_full_s, w_full_s;
    logic                 free_ar_s, free_aw_s, free_w_s;
    logic [AW-1:0]        ar_addr_s, aw_addr_s;
    logic [WW-1:0]        w_slot_s;
    logic [FE_DATA_W-1:0] w_data_s;
    logic [FE_NBYTES-1:0] w_strb_s;

    axil_hold_slot #(.WIDTH(AW)) u_ar_slot (
        .clk(clk), .reset(reset), .in_valid(s_arvalid), .in_data(s_araddr),
        .in_ready(s_arready), .free(free_ar_s), .full(ar_full_s), .data(ar_addr_s)
    );

    axil_hold_slot #(.WIDTH(AW)) u_aw_slot (
        .clk(clk), .reset(reset), .in_valid(s_awvalid), .in_data(s_awaddr),
        .in_ready(s_awready), .free(free_aw_s), .full(aw_full_s), .data(aw_addr_s)
    );

    axil_hold_slot #(.WIDTH(WW)) u_w_slot (
        .clk(clk), .reset(reset), .in_valid(s_wvalid), .in_data({s_wstrb, s_wdata}),
        .in_ready(s_wready), .free(free_w_s), .full(w_full_s), .data(w_slot_s)
    );

    assign w_data_s = w_slot_s[FE_DATA_W-1:0];
    assign w_strb_s = w_slot_s[FE_DATA_W +: FE_NBYTES];

    state_t               state_r, state_next_s;
    prio_t                prio_r, prio_next_s;
    logic                 valid_r, valid_next_s;
    logic [AW-1:0]        addr_r, addr_next_s;
    logic [FE_DATA_W-1:0] wdata_r, wdata_next_s;
    logic [FE_NBYTES-1:0] wstrb_r, wstrb_next_s;
    logic [FE_DATA_W-1:0] s_rdata_r, s_rdata_next_s;
    logic                 s_rvalid_r, s_rvalid_next_s;
    logic                 s_bvalid_r, s_bvalid_next_s;
    logic [1:0]           s_rresp_r, s_bresp_r;
    logic                 rd_pend_s, wr_pend_s, grant_rd_s, grant_wr_s;

    assign rd_pend_s  = ar_full_s;
    assign wr_pend_s  = aw_full_s & w_full_s;
    assign grant_rd_s = rd_pend_s & (~wr_pend_s | (prio_r == PRIO_READ));
    assign grant_wr_s = wr_pend_s & (~rd_pend_s | (prio_r == PRIO_WRITE));

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_next_s    = state_r;
        prio_next_s     = prio_r;
        valid_next_s    = valid_r;
        addr_next_s     = addr_r;
        wdata_next_s    = wdata_r;
        wstrb_next_s    = wstrb_r;
        s_rdata_next_s  = s_rdata_r;
        s_rvalid_next_s = s_rvalid_r;
        s_bvalid_next_s = s_bvalid_r;
        free_ar_s       = 1'b0;
        free_aw_s       = 1'b0;
        free_w_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_rd_s) begin
                    state_next_s = ST_RD_REQ;
                    prio_next_s  = PRIO_WRITE;
                    valid_next_s = 1'b1;
                    addr_next_s  = ar_addr_s;
                    wdata_next_s = '0;
                    wstrb_next_s = '0;
                end else if (grant_wr_s) begin
                    prio_next_s = PRIO_READ;
                    // An all-zero strobe would look like a read on the native bus,
                    // so such a write completes without any native access.
                    if (w_strb_s == '0) begin
                        state_next_s    = ST_WR_RSP;
                        s_bvalid_next_s = 1'b1;
                        free_aw_s       = 1'b1;
                        free_w_s        = 1'b1;
                    end else begin
                        state_next_s = ST_WR_REQ;
                        valid_next_s = 1'b1;
                        addr_next_s  = aw_addr_s;
                        wdata_next_s = w_data_s;
                        wstrb_next_s = w_strb_s;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (ready) begin
                    state_next_s    = ST_RD_RSP;
                    valid_next_s    = 1'b0;
                    addr_next_s     = '0;
                    wdata_next_s    = '0;
                    wstrb_next_s    = '0;
                    s_rdata_next_s  = rdata;
                    s_rvalid_next_s = 1'b1;
                    free_ar_s       = 1'b1;
                end else begin
                    state_next_s = ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                if (ready) begin
                    state_next_s    = ST_WR_RSP;
                    valid_next_s    = 1'b0;
                    addr_next_s     = '0;
                    wdata_next_s    = '0;
                    wstrb_next_s    = '0;
                    s_bvalid_next_s = 1'b1;
                    free_aw_s       = 1'b1;
                    free_w_s        = 1'b1;
                end else begin
                    state_next_s = ST_WR_REQ;
                end
            end
            ST_RD_RSP: begin
                if (s_rready) begin
                    state_next_s    = ST_IDLE;
                    s_rvalid_next_s = 1'b0;
                end else begin
                    state_next_s = ST_RD_RSP;
                end
            end
            ST_WR_RSP: begin
                if (s_bready) begin
                    state_next_s    = ST_IDLE;
                    s_bvalid_next_s = 1'b0;
                end else begin
                    state_next_s = ST_WR_RSP;
                end
            end
            default: begin
                state_next_s    = ST_IDLE;
                valid_next_s    = 1'b0;
                addr_next_s     = '0;
                wdata_next_s    = '0;
                wstrb_next_s    = '0;
                s_rvalid_next_s = 1'b0;
                s_bvalid_next_s = 1'b0;
            end
        endcase
    end

    // State, arbitration priority and all registered bridge outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            prio_r     <= PRIO_READ;
            valid_r    <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            wstrb_r    <= '0;
            s_rdata_r  <= '0;
            s_rvalid_r <= 1'b0;
            s_bvalid_r <= 1'b0;
            s_rresp_r  <= 2'b00;
            s_bresp_r  <= 2'b00;
        end else begin
            state_r    <= state_next_s;
            prio_r     <= prio_next_s;
            valid_r    <= valid_next_s;
            addr_r     <= addr_next_s;
            wdata_r    <= wdata_next_s;
            wstrb_r    <= wstrb_next_s;
            s_rdata_r  <= s_rdata_next_s;
            s_rvalid_r <= s_rvalid_next_s;
            s_bvalid_r <= s_bvalid_next_s;
            s_rresp_r  <= AXI_RESP_OKAY;
            s_bresp_r  <= AXI_RESP_OKAY;
        end
    end

    assign valid    = valid_r;
    assign addr     = addr_r;
    assign wdata    = wdata_r;
    assign wstrb    = wstrb_r;
    assign s_rdata  = s_rdata_r;
    assign s_rvalid = s_rvalid_r;
    assign s_rresp  = s_rresp_r;
    assign s_bvalid = s_bvalid_r;
    assign s_bresp  = s_bresp_r;

endmodule

// File: tb/tb_cache_axil_slave.sv
// Self-checking bench for cache_axil_slave (CTRL_CACHE=1, 33-bit addresses).
// A front-end model answers native requests from its own memory; the expected AXI
// results come from a separate byte-strobe memory model driven by the AXI traffic.
module tb_cache_axil_slave;
    localparam int AW = 33;
    localparam int DW = 32;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [AW-1:0] s_awaddr, s_araddr, addr;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic s_arvalid, s_arready, s_rvalid, s_rready, valid, ready;
    logic [DW-1:0] s_wdata, s_rdata, wdata, rdata;
    logic [NB-1:0] s_wstrb, wstrb;
    logic [1:0] s_bresp, s_rresp;

    cache_axil_slave #(.FE_ADDR_W(32), .FE_DATA_W(32), .CTRL_CACHE(1)) dut (
        .clk(clk), .reset(reset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .ready(ready), .rdata(rdata)
    );

    wire [110:0] all_outs = {s_awready, s_wready, s_arready, s_bvalid, s_bresp, s_rvalid,
                             s_rresp, s_rdata, valid, addr, wdata, wstrb};

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; logic [NB-1:0] s; int c; } req_t;
    req_t req_q[$];
    logic [DW-1:0] fe_mem[logic [AW-1:0]];
    logic [DW-1:0] exp_mem[logic [AW-1:0]];
    int resp_lat = 0;
    int ready_cyc = 0;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {31'b0, a[32]};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [NB-1:0] s);
        logic [DW-1:0] r = old;
        for (int i = 0; i < NB; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : init_word(a);
    endfunction

    // Front-end model: answers each native request after resp_lat extra valid cycles.
    initial begin
        int wc;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0, cur;
        logic [NB-1:0] s0;
        req_t r;
        ready = 1'b0; rdata = '0; wc = 0; a0 = '0; d0 = '0; s0 = '0;
        forever begin
            @(negedge clk);
            ready = 1'b0;
            rdata = $urandom;
            if (reset || !valid) begin
                wc = 0;
            end else begin
                if (wc == 0) begin
                    a0 = addr; d0 = wdata; s0 = wstrb;
                end else begin
                    n_checks++;
                    if ({addr, wdata, wstrb} !== {a0, d0, s0}) begin
                        n_fail++;
                        $display("FAIL native_stable: addr=%h wdata=%h wstrb=%h, required addr=%h wdata=%h wstrb=%h",
                                 addr, wdata, wstrb, a0, d0, s0);
                    end
                end
                if (wc >= resp_lat) begin
                    ready = 1'b1;
                    ready_cyc = cyc;
                    r.a = addr; r.d = wdata; r.s = wstrb; r.c = cyc;
                    req_q.push_back(r);
                    cur = fe_mem.exists(addr) ? fe_mem[addr] : init_word(addr);
                    if (wstrb == '0) rdata = cur;
                    else fe_mem[addr] = merge(cur, wdata, wstrb);
                    wc = 0;
                end else begin
                    wc++;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic ar_send(input logic [AW-1:0] a, output int hs);
        int n = 0;
        s_araddr = a; s_arvalid = 1'b1;
        while (!s_arready && n < 100) begin @(negedge clk); n++; end
        n_checks++;
        if (s_arready !== 1'b1) begin n_fail++; $display("FAIL ar_handshake: arready=%b, required 1", s_arready); end
        hs = cyc;
        @(negedge clk); s_arvalid = 1'b0; s_araddr = '0;
    endtask

    task automatic aw_send(input logic [AW-1:0] a, output int hs);
        int n = 0;
        s_awaddr = a; s_awvalid = 1'b1;
        while (!s_awready && n < 100) begin @(negedge clk); n++; end
        n_checks++;
        if (s_awready !== 1'b1) begin n_fail++; $display("FAIL aw_handshake: awready=%b, required 1", s_awready); end
        hs = cyc;
        @(negedge clk); s_awvalid = 1'b0; s_awaddr = '0;
    endtask

    task automatic w_send(input logic [DW-1:0] d, input logic [NB-1:0] s, output int hs);
        int n = 0;
        s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
        while (!s_wready && n < 100) begin @(negedge clk); n++; end
        n_checks++;
        if (s_wready !== 1'b1) begin n_fail++; $display("FAIL w_handshake: wready=%b, required 1", s_wready); end
        hs = cyc;
        @(negedge clk); s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
    endtask

    task automatic r_recv(output logic [DW-1:0] d, output logic [1:0] rr, output int c);
        int n = 0;
        s_rready = 1'b1;
        while (!s_rvalid && n < 100) begin @(negedge clk); n++; end
        n_checks++;
        if (s_rvalid !== 1'b1) begin n_fail++; $display("FAIL r_timeout: rvalid=%b, required 1", s_rvalid); end
        d = s_rdata; rr = s_rresp; c = cyc;
        @(negedge clk); s_rready = 1'b0;
    endtask

    task automatic b_recv(output logic [1:0] br, output int c);
        int n = 0;
        s_bready = 1'b1;
        while (!s_bvalid && n < 100) begin @(negedge clk); n++; end
        n_checks++;
        if (s_bvalid !== 1'b1) begin n_fail++; $display("FAIL b_timeout: bvalid=%b, required 1", s_bvalid); end
        br = s_bresp; c = cyc;
        @(negedge clk); s_bready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h, required 0", all_outs); end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({s_arready, s_awready, s_wready} !== 3'b000) begin
            n_fail++; $display("FAIL ready_before_edge: got %b, required 000", {s_arready, s_awready, s_wready});
        end
        @(negedge clk);
        n_checks++;
        if ({s_arready, s_awready, s_wready} !== 3'b111) begin
            n_fail++; $display("FAIL ready_after_release: got %b, required 111", {s_arready, s_awready, s_wready});
        end
    endtask

    task automatic test_read();
        logic [DW-1:0] d; logic [1:0] rr; int hs, rc;
        fe_mem[33'h48] = 32'hDEADBEEF; exp_mem[33'h48] = 32'hDEADBEEF;
        req_q.delete(); resp_lat = 2;
        ar_send(33'h48, hs);
        r_recv(d, rr, rc);
        n_checks++;
        if (req_q.size() != 1 || req_q[0].a !== 33'h48 || req_q[0].s !== 4'h0) begin
            n_fail++; $display("FAIL read_native: count=%0d, required one read at addr 48 wstrb 0", req_q.size());
        end
        n_checks++;
        if (d !== 32'hDEADBEEF || rr !== 2'b00) begin
            n_fail++; $display("FAIL read_data: got %h resp %b, required deadbeef resp 00", d, rr);
        end
        n_checks++;
        if (rc != ready_cyc + 1) begin n_fail++; $display("FAIL read_rvalid_delay: got %0d, required %0d", rc, ready_cyc + 1); end
    endtask

    task automatic test_read_min_latency_ctrl();
        logic [DW-1:0] d; logic [1:0] rr; int hs, rc;
        logic [AW-1:0] a;
        a = {1'b1, 32'($urandom) & 32'h0000_FFFC};
        req_q.delete(); resp_lat = 0;
        ar_send(a, hs);
        r_recv(d, rr, rc);
        n_checks++;
        if (rc - hs != 3) begin n_fail++; $display("FAIL min_ar_to_r: got %0d cycles, required 3", rc - hs); end
        n_checks++;
        if (req_q.size() != 1 || req_q[0].a !== a) begin
            n_fail++; $display("FAIL ctrl_msb_addr: count=%0d addr=%h, required addr=%h", req_q.size(),
                               (req_q.size() > 0) ? req_q[0].a : '0, a);
        end
        n_checks++;
        if (d !== exp_read(a)) begin n_fail++; $display("FAIL ctrl_read_data: got %h, required %h", d, exp_read(a)); end
    endtask

    task automatic test_write_w_first();
        logic [1:0] br; int hw, ha, bc;
        req_q.delete(); resp_lat = 1;
        w_send(32'hCAFEEFAC, 4'hF, hw);
        repeat (3) @(negedge clk);
        aw_send(33'h15E4, ha);
        b_recv(br, bc);
        exp_mem[33'h15E4] = merge(exp_read(33'h15E4), 32'hCAFEEFAC, 4'hF);
        n_checks++;
        if (req_q.size() != 1 || req_q[0].a !== 33'h15E4 || req_q[0].d !== 32'hCAFEEFAC || req_q[0].s !== 4'hF) begin
            n_fail++; $display("FAIL write_native: count=%0d, required one write 15e4/cafeefac/f", req_q.size());
        end
        n_checks++;
        if (br !== 2'b00 || bc != ready_cyc + 1) begin
            n_fail++; $display("FAIL write_bresp: resp=%b cyc=%0d, required 00 at %0d", br, bc, ready_cyc + 1);
        end
    endtask

    task automatic pair(input logic [AW-1:0] ar_a, input logic [AW-1:0] aw_a, output logic [DW-1:0] d, output int h1, output int h2);
        logic [DW-1:0] wd; logic [NB-1:0] ws; logic [1:0] rr, br; int h3, rc, bc;
        wd = $urandom; ws = 4'($urandom_range(1, 15));
        fork
            ar_send(ar_a, h1);
            aw_send(aw_a, h2);
            w_send(wd, ws, h3);
        join
        fork
            r_recv(d, rr, rc);
            b_recv(br, bc);
        join
        exp_mem[aw_a] = merge(exp_read(aw_a), wd, ws);
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] d, e; logic [1:0] rr; int h1, h2, hs, rc;
        do_reset();
        req_q.delete(); resp_lat = $urandom_range(0, 2);
        e = exp_read(33'h100);
        pair(33'h100, 33'h204, d, h1, h2);
        n_checks++;
        if (h1 != h2) begin n_fail++; $display("FAIL pair_same_cycle: ar at %0d aw at %0d, required equal", h1, h2); end
        n_checks++;
        if (req_q.size() != 2 || req_q[0].s !== 4'h0 || req_q[0].a !== 33'h100 || req_q[1].a !== 33'h204) begin
            n_fail++; $display("FAIL first_pair_read_first: count=%0d, required read 100 then write 204", req_q.size());
        end
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL pair_read_data: got %h, required %h", d, e); end
        // Grants so far: read, write, then this read, so the next contested grant is the write.
        ar_send(33'h108, hs);
        r_recv(d, rr, rc);
        req_q.delete();
        pair(33'h10C, 33'h110, d, h1, h2);
        n_checks++;
        if (req_q.size() != 2 || req_q[0].s === 4'h0 || req_q[0].a !== 33'h110 || req_q[1].a !== 33'h10C) begin
            n_fail++; $display("FAIL second_pair_write_first: count=%0d, required write 110 then read 10c", req_q.size());
        end
    endtask

    task automatic test_wstrb0();
        logic [1:0] br; int h1, h2, bc, hmax;
        req_q.delete();
        fork
            aw_send(33'h1_0000_0040, h1);
            w_send($urandom, 4'h0, h2);
        join
        b_recv(br, bc);
        hmax = (h1 > h2) ? h1 : h2;
        n_checks++;
        if (req_q.size() != 0) begin n_fail++; $display("FAIL wstrb0_no_native: got %0d requests, required 0", req_q.size()); end
        n_checks++;
        if (br !== 2'b00 || bc - hmax > 2) begin
            n_fail++; $display("FAIL wstrb0_bvalid: resp=%b delay=%0d, required 00 within 2", br, bc - hmax);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d1, d; logic [1:0] rr; int h, n, rc1, rc2;
        req_q.delete(); resp_lat = $urandom_range(0, 3);
        ar_send(33'h300, h);
        n = 0;
        while (!s_rvalid && n < 50) begin @(negedge clk); n++; end
        d1 = s_rdata;
        ar_send(33'h304, h);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (s_rvalid !== 1'b1 || s_rdata !== d1 || req_q.size() != 1) begin
                n_fail++; $display("FAIL rdata_hold: rvalid=%b rdata=%h reqs=%0d, required 1 %h 1", s_rvalid, s_rdata, d1, req_q.size());
            end
        end
        r_recv(d, rr, rc1);
        n_checks++;
        if (d !== exp_read(33'h300)) begin n_fail++; $display("FAIL bp_first_data: got %h, required %h", d, exp_read(33'h300)); end
        r_recv(d, rr, rc2);
        n_checks++;
        if (d !== exp_read(33'h304)) begin n_fail++; $display("FAIL bp_second_data: got %h, required %h", d, exp_read(33'h304)); end
        n_checks++;
        if (req_q.size() != 2 || req_q[1].c <= rc1) begin
            n_fail++; $display("FAIL bp_second_issue: reqs=%0d, required second issued after cycle %0d", req_q.size(), rc1);
        end
    endtask

    task automatic test_reset_mid();
        int h, n; logic seen;
        req_q.delete(); resp_lat = 20;
        ar_send(33'h400, h);
        n = 0;
        while (!valid && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid: valid=%b, required 1", valid); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (all_outs !== '0) begin n_fail++; $display("FAIL mid_reset_outputs: got %h, required 0", all_outs); end
        reset = 1'b0;
        #1;
        n_checks++;
        if (s_arready !== 1'b0) begin n_fail++; $display("FAIL mid_arready_early: got %b, required 0", s_arready); end
        @(negedge clk);
        n_checks++;
        if (s_arready !== 1'b1) begin n_fail++; $display("FAIL mid_arready: got %b, required 1", s_arready); end
        s_rready = 1'b1; seen = 1'b0;
        repeat (8) begin @(negedge clk); seen |= (s_rvalid | valid); end
        s_rready = 1'b0;
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_response: rvalid/valid seen=%b, required 0", seen); end
        resp_lat = 0;
    endtask

    task automatic test_random();
        logic [AW-1:0] a; logic [DW-1:0] d, wd; logic [NB-1:0] ws; logic [1:0] r;
        int h1, h2, c, da, dw;
        req_t q;
        req_q.delete();
        for (int it = 0; it < 40; it++) begin
            a = '0;
            a[4:2] = 3'($urandom_range(0, 7));
            a[1:0] = 2'($urandom_range(0, 3));
            a[AW-1] = 1'($urandom_range(0, 1));
            resp_lat = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) begin
                ar_send(a, h1);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                r_recv(d, r, c);
                q = (req_q.size() > 0) ? req_q.pop_front() : '{'0, '0, 4'hF, 0};
                n_checks++;
                if (d !== exp_read(a) || r !== 2'b00 || q.a !== a || q.s !== 4'h0) begin
                    n_fail++; $display("FAIL rand_read: addr=%h data=%h resp=%b native=%h/%h, required %h 00 %h/0",
                                       a, d, r, q.a, q.s, exp_read(a), a);
                end
            end else begin
                wd = $urandom; ws = 4'($urandom_range(0, 15));
                da = $urandom_range(0, 3); dw = $urandom_range(0, 3);
                fork
                    begin repeat (da) @(negedge clk); aw_send(a, h1); end
                    begin repeat (dw) @(negedge clk); w_send(wd, ws, h2); end
                join
                b_recv(r, c);
                if (ws != 4'h0) exp_mem[a] = merge(exp_read(a), wd, ws);
                n_checks++;
                if (r !== 2'b00 || (ws == 4'h0 && req_q.size() != 0) ||
                    (ws != 4'h0 && (req_q.size() != 1 || req_q[0].a !== a || req_q[0].d !== wd || req_q[0].s !== ws))) begin
                    n_fail++; $display("FAIL rand_write: addr=%h strb=%h resp=%b reqs=%0d, required okay and matching native write",
                                       a, ws, r, req_q.size());
                end
                req_q.delete();
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        test_reset();
        test_read();
        test_read_min_latency_ctrl();
        test_write_w_first();
        test_simultaneous();
        test_wstrb0();
        test_backpressure();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
